// File: rtl/axil_master.sv
// axil_master: turns single-beat word commands into AXI4-Lite write/read transactions, one in flight.
// Latency: accept at cycle 0, AW/W/AR valid at cycle 1, B/R ready at cycle 2, response at cycle 3 (slave always ready).
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready. AXIL_MASTER_ERR_COUNT_EN adds err_count.
module axil_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      axi_clock,
    input  logic                      rst,
    // command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response side
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    // AW channel
    output logic [ADDR_WIDTH+1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    // B channel
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    // AR channel
    output logic [ADDR_WIDTH+1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
`ifdef AXIL_MASTER_ERR_COUNT_EN
    ,
    output logic [15:0]               err_count
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WAIT_B = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_WAIT_R = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]              state_q,  state_d;
    logic                    we_q,     we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q,  wstrb_d;
    // AW and W complete independently; each pending bit clears on its own handshake
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q,  w_pend_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic [1:0]              resp_q,   resp_d;

    // Next-state and payload capture for the single outstanding transaction
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    // writes report zero read data; reads overwrite this on capture
                    rdata_d = '0;
                    if (cmd_we) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        state_d   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (aw_pend_q && m_axil_awready) aw_pend_d = 1'b0;
                if (w_pend_q && m_axil_wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)     state_d   = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    state_d = S_RESP;
                end
            end
            S_READ: begin
                if (m_axil_arready) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and payload registers; reset abandons any in-flight transaction
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXIL_MASTER_ERR_COUNT_EN
    logic [15:0] err_cnt_q;
    logic        err_evt;

    assign err_evt = ((state_q == S_WAIT_B) && m_axil_bvalid && (m_axil_bresp != 2'b00)) ||
                     ((state_q == S_WAIT_R) && m_axil_rvalid && (m_axil_rresp != 2'b00));

    // Saturating count of non-OKAY responses
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    // All outputs decode directly from registers, so payloads stay stable under valid
    assign cmd_ready      = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_we         = we_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign m_axil_awaddr  = {addr_q, 2'b00};
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = (state_q == S_WRITE) && aw_pend_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = (state_q == S_WRITE) && w_pend_q;
    assign m_axil_bready  = (state_q == S_WAIT_B);
    assign m_axil_araddr  = {addr_q, 2'b00};
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state_q == S_READ);
    assign m_axil_rready  = (state_q == S_WAIT_R);

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-lite data width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, command word-address width; AXI byte address is ADDR_WIDTH+2 bits.
REQ-003 SHALL have port axi_clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have command port group: cmd_valid in 1, cmd_ready out 1, cmd_we in 1 (1=write, 0=read).
REQ-006 SHALL have command payload: cmd_addr in ADDR_WIDTH (word address), cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8.
REQ-007 SHALL have response port group: rsp_valid out 1, rsp_ready in 1, rsp_we out 1 (echo of cmd_we).
REQ-008 SHALL have response payload: rsp_rdata out DATA_WIDTH, rsp_resp out 2 (captured BRESP/RRESP).
REQ-009 SHALL have AW channel: m_axil_awaddr out ADDR_WIDTH+2, m_axil_awprot out 3, m_axil_awvalid out 1, m_axil_awready in 1.
REQ-010 SHALL have W channel: m_axil_wdata out DATA_WIDTH, m_axil_wstrb out DATA_WIDTH/8, m_axil_wvalid out 1, m_axil_wready in 1.
REQ-011 SHALL have B channel: m_axil_bresp in 2, m_axil_bvalid in 1, m_axil_bready out 1.
REQ-012 SHALL have AR channel: m_axil_araddr out ADDR_WIDTH+2, m_axil_arprot out 3, m_axil_arvalid out 1, m_axil_arready in 1.
REQ-013 SHALL have R channel: m_axil_rdata in DATA_WIDTH, m_axil_rresp in 2, m_axil_rvalid in 1, m_axil_rready out 1.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP; exactly one transaction outstanding.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; command accepted on cmd_valid&&cmd_ready, payload latched that cycle.
REQ-016 SHALL on accept go to WRITE if cmd_we=1, else READ.
REQ-017 SHALL drive awaddr/araddr = {latched cmd_addr, 2'b00}, awprot=arprot=3'b000, wdata/wstrb from latch.
REQ-018 SHALL in WRITE assert awvalid and wvalid from the cycle after accept; each drops independently the cycle after its own handshake; neither drops before its handshake.
REQ-019 SHALL leave WRITE for WAIT_B only after both AW and W handshakes completed, in either order or same cycle.
REQ-020 SHALL in WAIT_B assert bready=1; bready=0 in all other states; on bvalid capture bresp, go to RESP.
REQ-021 SHALL in READ assert arvalid until arready; then WAIT_R with rready=1 (0 elsewhere); on rvalid capture rdata/rresp, go to RESP.
REQ-022 SHALL in RESP hold rsp_valid=1 with stable payload until rsp_ready; rsp_rdata=0 for writes; then IDLE.
REQ-023 SHALL give minimum latency, all ready inputs high: accept at cycle 0, AW/W/AR valid cycle 1, bready/rready cycle 2, rsp_valid cycle 3; cmd_ready cycle 4 if rsp_ready=1 at cycle 3.
REQ-024 SHALL ignore bvalid/rvalid outside WAIT_B/WAIT_R; cmd_valid outside IDLE has no effect.
REQ-025 SHALL keep all AXI payload outputs stable while corresponding valid is high.

Reset
REQ-026 SHALL on rst=1 at a clock edge enter IDLE regardless of current state, including mid-transaction.
REQ-027 SHALL reset outputs: cmd_ready=1 after reset release, rsp_valid=0, awvalid=wvalid=arvalid=0, bready=rready=0, rsp_rdata=0, rsp_resp=0, rsp_we=0, addr/data outputs 0.
REQ-028 SHALL not preserve any in-flight transaction across reset; system-level reset of slave is required.

Configuration
REQ-029 SHALL, with macro AXIL_MASTER_ERR_COUNT_EN defined, add output err_count (16 bits), counting captured bresp/rresp != 2'b00, saturating at 16'hFFFF, cleared by rst.
REQ-030 SHALL, without AXIL_MASTER_ERR_COUNT_EN, omit port err_count and its counter; all other behaviour identical.

Verification
REQ-031 SHALL verify write: cmd_we=1, addr=0x005, wdata=0xDEADBEEF, wstrb=0xF, slave always ready -> awaddr=0x014, bready cycle 2, rsp_valid cycle 3, rsp_resp=00, rsp_rdata=0.
REQ-032 SHALL verify read: cmd_we=0, addr=0x3FF, slave returns 0x12345678 after 4 waits -> araddr=0xFFC, rsp_rdata=0x12345678, rsp_we=0.
REQ-033 SHALL verify split handshake: wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held, bready asserted only after AW done.
REQ-034 SHALL verify backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0, new cmd_valid not accepted.
REQ-035 SHALL verify reset in WAIT_R: rst pulsed one cycle -> next cycle all valids/readies 0, cmd_ready=1, no rsp_valid.
REQ-036 SHALL verify with AXIL_MASTER_ERR_COUNT_EN: three transactions with resp 10, 00, 11 -> err_count=2.
